shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_pkg.sv | 23 ++
 rtl/shift_reg_unit.sv | 33 +++
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM states, shifter select
// encodings and the step-count width.
package shift_sequencer_pkg;

    localparam int COUNT_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;

endpackage

// File: rtl/shift_reg_unit.sv
// Four-function shift register: hold, arithmetic right, logical left, load.
module shift_reg_unit
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_r;

    // Shifter register update selected by the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {WIDTH{1'b0}};
        end else begin
            case (select)
                SEL_HOLD: data_r <= data_r;
                SEL_SHR:  data_r <= {data_r[WIDTH-1], data_r[WIDTH-1:1]};
                SEL_SHL:  data_r <= {data_r[WIDTH-2:0], 1'b0};
                SEL_LOAD: data_r <= data_in;
                default:  data_r <= data_r;
            endcase
        end
    end

    assign data_out = data_r;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven shift sequencer: accepts one command, loads the shifter,
// steps it count times and reports the result with a one-cycle pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               cmd_dir,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic               result_ovf,
    output logic               busy
);

    state_t             state_r;
    state_t             state_next;
    sel_t               select_s;
    logic               accept_s;
    logic [WIDTH-1:0]   data_r;
    logic               dir_r;
    logic [COUNT_W-1:0] remaining_r;
    logic               ovf_r;
    logic               ready_r;
    logic               valid_r;
    logic               busy_r;
    logic [WIDTH-1:0]   shift_q_s;

    assign accept_s = (state_r == IDLE) && cmd_valid;

    // Next-state and shifter select decode.
    always_comb begin
        state_next = state_r;
        select_s   = SEL_HOLD;
        case (state_r)
            IDLE: begin
                if (cmd_valid) state_next = LOAD;
                else           state_next = IDLE;
            end
            LOAD: begin
                select_s = SEL_LOAD;
                if (remaining_r != COUNT_ZERO) state_next = SHIFT;
                else                           state_next = DONE;
            end
            SHIFT: begin
                if (dir_r) select_s = SEL_SHL;
                else       select_s = SEL_SHR;
                if (remaining_r == COUNT_ONE) state_next = DONE;
                else                          state_next = SHIFT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            ready_r <= (state_next == IDLE);
            valid_r <= (state_next == DONE);
            busy_r  <= (state_next != IDLE);
        end
    end

    // Command latch, step counter and sticky left-shift overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r      <= {WIDTH{1'b0}};
            dir_r       <= 1'b0;
            remaining_r <= COUNT_ZERO;
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            data_r      <= cmd_data;
            dir_r       <= cmd_dir;
            remaining_r <= cmd_count;
            ovf_r       <= 1'b0;
        end else if (state_r == SHIFT) begin
            remaining_r <= remaining_r - COUNT_ONE;
            // the bit leaving the MSB on a left step is lost
            if (dir_r && shift_q_s[WIDTH-1]) ovf_r <= 1'b1;
            else                             ovf_r <= ovf_r;
        end else begin
            remaining_r <= remaining_r;
            ovf_r       <= ovf_r;
        end
    end

    shift_reg_unit #(.WIDTH(WIDTH)) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .select   (select_s),
        .data_in  (data_r),
        .data_out (shift_q_s)
    );

    assign cmd_ready    = ready_r;
    assign result_valid = valid_r;
    assign busy         = busy_r;
    assign result       = shift_q_s;
    assign result_ovf   = ovf_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, reset
// corner cases, random commands and a back-to-back command stream.
module tb_shift_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_dir = 1'b0;
    logic [2:0]   cmd_count = '0;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ovf;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        logic [2:0]   count;
        logic [W-1:0] exp_r;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         dir;
        logic [2:0]   c;
    } cmd_t;

    shift_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .result       (result),
        .result_valid (result_valid),
        .result_ovf   (result_ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: whole shift done with integer arithmetic on the loaded value.
    function automatic void model(input logic [W-1:0] d, input logic dir,
                                  input logic [2:0] cnt,
                                  output logic [W-1:0] r, output logic ovf);
        int v;
        if (dir == 1'b0) begin
            v = d[W-1] ? (int'(d) - (1 << W)) : int'(d);
            v = v >>> cnt;
            r = v[W-1:0];
            ovf = 1'b0;
        end else begin
            v = int'(d) << cnt;
            r = v[W-1:0];
            ovf = ((v >> W) != 0);
        end
    endfunction

    task automatic accept_cmd(input logic [W-1:0] d, input logic dir,
                              input logic [2:0] cnt, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        ok = cmd_ready;
        if (!ok) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_count = cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [W-1:0] d, input logic dir,
                           input logic [2:0] cnt, input bit scramble,
                           output logic [W-1:0] res, output logic ovf,
                           output int lat);
        bit ok;
        res = '0;
        ovf = 1'b0;
        lat = -1;
        accept_cmd(d, dir, cnt, ok);
        if (!ok) return;
        lat = 1;
        while (!result_valid && lat < 20) begin
            if (scramble) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_data  = 4'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_count = 3'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        res = result;
        ovf = result_ovf;
        if (!result_valid) lat = -1;
        @(negedge clk);
        check("valid_one_cycle", int'(result_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_ready", int'(cmd_ready), 1);
        check("result_hold", int'(result), int'(res));
    endtask

    task automatic reset_mid(input string name, input logic [W-1:0] d,
                             input logic dir, input logic [2:0] cnt,
                             input int k, input bit expect_valid);
        bit ok;
        int lat;
        int pulses = 0;
        accept_cmd(d, dir, cnt, ok);
        if (!ok) return;
        lat = 1;
        while (lat < k) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_pre_valid"}, int'(result_valid), int'(expect_valid));
        reset = 1'b1;
        @(negedge clk);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_result"}, int'(result), 0);
        check({name, "_ready"}, int'(cmd_ready), 1);
        check({name, "_ovf"}, int'(result_ovf), 0);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check({name, "_no_pulse"}, pulses, 0);
    endtask

    vec_t         vecs[8];
    cmd_t         q[$];
    cmd_t         e;
    logic [W-1:0] res;
    logic [W-1:0] exp_r;
    logic         ovf;
    logic         exp_ovf;
    logic [W-1:0] rd;
    logic         rdir;
    logic [2:0]   rc;
    int           lat;
    int           last_acc;
    int           last_cnt;

    initial begin
        vecs[0] = '{4'b1001, 1'b0, 3'd2, 4'b1110, 1'b0};
        vecs[1] = '{4'b0101, 1'b1, 3'd1, 4'b1010, 1'b0};
        vecs[2] = '{4'b0101, 1'b1, 3'd3, 4'b1000, 1'b1};
        vecs[3] = '{4'b0110, 1'b0, 3'd0, 4'b0110, 1'b0};
        vecs[4] = '{4'b1110, 1'b1, 3'd0, 4'b1110, 1'b0};
        vecs[5] = '{4'b1000, 1'b0, 3'd7, 4'b1111, 1'b0};
        vecs[6] = '{4'b0111, 1'b0, 3'd3, 4'b0000, 1'b0};
        vecs[7] = '{4'b1111, 1'b1, 3'd7, 4'b0000, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_ovf", int'(result_ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].data, vecs[i].dir, vecs[i].count, 1'b0, res, ovf, lat);
            check($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].exp_r));
            check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_latency", i), lat, int'(vecs[i].count) + 2);
        end

        reset_mid("rst_shift", 4'b1011, 1'b1, 3'd5, 3, 1'b0);
        reset_mid("rst_done", 4'b1000, 1'b1, 3'd1, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rd   = 4'($urandom);
            rdir = 1'($urandom);
            rc   = 3'($urandom);
            model(rd, rdir, rc, exp_r, exp_ovf);
            run_cmd(rd, rdir, rc, 1'b1, res, ovf, lat);
            check($sformatf("rand%0d_result", i), int'(res), int'(exp_r));
            check($sformatf("rand%0d_ovf", i), int'(ovf), int'(exp_ovf));
            check($sformatf("rand%0d_latency", i), lat, int'(rc) + 2);
        end

        // Back-to-back stream: cmd_valid held high, new data every cycle.
        last_acc = -1;
        last_cnt = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            if (result_valid) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    model(e.d, e.dir, e.c, exp_r, exp_ovf);
                    check("stream_result", int'(result), int'(exp_r));
                    check("stream_ovf", int'(result_ovf), int'(exp_ovf));
                end
            end
            cmd_valid = (cyc < 100);
            cmd_data  = 4'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_count = 3'($urandom);
            if (cmd_ready && cmd_valid) begin
                if (last_acc >= 0) check("stream_spacing", cyc - last_acc, last_cnt + 3);
                last_acc = cyc;
                last_cnt = int'(cmd_count);
                q.push_back('{cmd_data, cmd_dir, cmd_count});
            end
        end
        cmd_valid = 1'b0;
        check("stream_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
